// File: rtl/rf_wb_sched_if.sv
// Valid/ready channel that carries multi-cycle unit results into the write-port scheduler.
interface rf_wb_sched_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          mc_valid;
    logic          mc_ready;
    logic [AW-1:0] mc_wa;
    logic [DW-1:0] mc_wd;

    modport master (output mc_valid, output mc_wa, output mc_wd, input mc_ready);
    modport slave  (input mc_valid, input mc_wa, input mc_wd, output mc_ready);
endinterface

// File: rtl/rf_wb_sched.sv
// Register-file write-port scheduler: core writeback has priority, multi-cycle results queue
// in a small FIFO, and a busy scoreboard flags read hazards on registers still in flight.
module rf_wb_sched #(
    parameter int DW         = 32,
    parameter int AW         = 5,
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          core_we,
    input  logic [AW-1:0] core_wa,
    input  logic [DW-1:0] core_wd,
    rf_wb_sched_if.slave  mc,
    input  logic          issue_claim,
    input  logic [AW-1:0] issue_wa,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic          hazard1,
    output logic          hazard2,
    output logic          stall_core,
    output logic          rf_we,
    output logic [AW-1:0] rf_wa,
    output logic [DW-1:0] rf_wd,
    output logic          err
);
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW   = PW + 1;
    localparam int SW   = $clog2(STARVE_MAX + 1);
    localparam int NREG = 1 << AW;

    logic [AW-1:0]   fifo_wa [DEPTH];
    logic [DW-1:0]   fifo_wd [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [SW-1:0]   starve_cnt;
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_next;

    logic          empty;
    logic          full;
    logic          core_eff;
    logic          drain;
    logic          push;
    logic          err_event;
    logic [AW-1:0] head_wa;
    logic [DW-1:0] head_wd;

    // Every grant is gated by reset so nothing is written or accepted in a reset cycle.
    assign empty       = (count == '0);
    assign full        = (count == CW'(DEPTH));
    assign head_wa     = fifo_wa[rd_ptr];
    assign head_wd     = fifo_wd[rd_ptr];
    assign mc.mc_ready = ~full & ~reset;
    assign stall_core  = (starve_cnt == SW'(STARVE_MAX)) & ~empty & ~reset;
    assign core_eff    = core_we & (core_wa != '0) & ~stall_core & ~reset;
    assign drain       = ~empty & (~core_eff | stall_core) & ~reset;
    assign push        = mc.mc_valid & mc.mc_ready;

    assign hazard1 = busy[ra1] & (ra1 != '0);
    assign hazard2 = busy[ra2] & (ra2 != '0);

    assign err_event = (issue_claim & (issue_wa != '0) & busy[issue_wa])
                     | (core_eff & busy[core_wa])
                     | (push & ~busy[mc.mc_wa]);

    always_comb begin
        rf_we = 1'b0;
        rf_wa = '0;
        rf_wd = '0;
        if (core_eff) begin
            rf_we = 1'b1;
            rf_wa = core_wa;
            rf_wd = core_wd;
        end else if (drain && head_wa != '0) begin
            rf_we = 1'b1;
            rf_wa = head_wa;
            rf_wd = head_wd;
        end
    end

    // A claim in the same cycle as a drain of that register keeps it busy.
    always_comb begin
        busy_next = busy;
        if (drain) busy_next[head_wa] = 1'b0;
        if (issue_claim) busy_next[issue_wa] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            fifo_wa[wr_ptr] <= mc.mc_wa;
            fifo_wd[wr_ptr] <= mc.mc_wd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
            busy       <= '0;
            err        <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (drain) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(drain);
            if (empty || drain)
                starve_cnt <= '0;
            else if (core_eff && starve_cnt != SW'(STARVE_MAX))
                starve_cnt <= starve_cnt + 1'b1;
            busy <= busy_next;
            if (err_event) err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_rf_wb_sched.sv
// Scoreboard bench: stimulus queues each expected register-file write, a negedge monitor pops
// and compares whenever rf_we is asserted; status flags are checked inline.
module tb_rf_wb_sched;
    localparam int DW = 32;
    localparam int AW = 5;

    typedef struct {
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          core_we, issue_claim;
    logic [AW-1:0] core_wa, issue_wa, ra1, ra2;
    logic [DW-1:0] core_wd;
    logic          hazard1, hazard2, stall_core, rf_we, err;
    logic [AW-1:0] rf_wa;
    logic [DW-1:0] rf_wd;

    wr_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    rf_wb_sched_if #(.DW(DW), .AW(AW)) mc_bus ();

    rf_wb_sched #(.DW(DW), .AW(AW), .DEPTH(2), .STARVE_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .core_we(core_we), .core_wa(core_wa), .core_wd(core_wd),
        .mc(mc_bus),
        .issue_claim(issue_claim), .issue_wa(issue_wa),
        .ra1(ra1), .ra2(ra2),
        .hazard1(hazard1), .hazard2(hazard2), .stall_core(stall_core),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        wr_t e;
        if (rf_we === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("[TB] FAIL unexpected_write: got wa=%0d wd=0x%0h, none expected", rf_wa, rf_wd);
            end else begin
                e = exp_q.pop_front();
                if (rf_wa !== e.wa || rf_wd !== e.wd) begin
                    n_bad++;
                    $display("[TB] FAIL rf_write: got wa=%0d wd=0x%0h, expected wa=%0d wd=0x%0h",
                             rf_wa, rf_wd, e.wa, e.wd);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        wr_t e;
        e.wa = wa;
        e.wd = wd;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        core_we = 1'b0; core_wa = '0; core_wd = '0;
        issue_claim = 1'b0; issue_wa = '0;
        ra1 = '0; ra2 = '0;
        mc_bus.mc_valid = 1'b0; mc_bus.mc_wa = '0; mc_bus.mc_wd = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic half();
        @(negedge clk);
    endtask

    task automatic claim(input logic [AW-1:0] wa);
        idle(); issue_claim = 1'b1; issue_wa = wa; tick();
    endtask

    task automatic mc_push(input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        mc_bus.mc_valid = 1'b1; mc_bus.mc_wa = wa; mc_bus.mc_wd = wd;
    endtask

    task automatic core_write(input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        core_we = 1'b1; core_wa = wa; core_wd = wd;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        tick(); tick();
        half();
        check("rst_mc_ready", mc_bus.mc_ready, 0);
        check("rst_stall", stall_core, 0);
        check("rst_rf_we", rf_we, 0);
        tick();
        reset = 1'b0;
        ra1 = 5;
        half();
        check("post_rst_ready", mc_bus.mc_ready, 1);
        check("post_rst_err", err, 0);
        check("post_rst_hazard1", hazard1, 0);
        tick();

        // Claim r5, push its result with the core idle.
        claim(5);
        idle(); ra1 = 5; mc_push(5, 32'h1234); push_exp(5, 32'h1234);
        half(); check("t1_hazard_busy", hazard1, 1); check("t1_ready", mc_bus.mc_ready, 1); tick();
        idle(); ra1 = 5;
        half(); check("t1_rf_we", rf_we, 1); check("t1_hazard_drain", hazard1, 1); tick();
        idle(); ra1 = 5;
        half(); check("t1_hazard_after", hazard1, 0); check("t1_rf_we_after", rf_we, 0); tick();

        // Core hogs the port; r7 waits until the starvation stall.
        claim(7);
        for (int i = 0; i < 6; i++) begin
            idle(); core_write(3, 32'h300 + i);
            if (i == 0) mc_push(7, 32'h77);
            if (i < 5) push_exp(3, 32'h300 + i);
            else push_exp(7, 32'h77);
            half(); check($sformatf("t2_stall_%0d", i), stall_core, (i == 5) ? 1 : 0); tick();
        end
        idle();
        half(); check("t2_stall_clear", stall_core, 0); check("t2_err", err, 0); tick();

        // Fill the FIFO behind core writes, then drain in order.
        claim(8);
        claim(9);
        idle(); core_write(3, 32'h400); mc_push(8, 32'h88); push_exp(3, 32'h400);
        half(); check("t3_ready0", mc_bus.mc_ready, 1); tick();
        idle(); core_write(3, 32'h401); mc_push(9, 32'h99); push_exp(3, 32'h401);
        half(); check("t3_ready1", mc_bus.mc_ready, 1); tick();
        idle(); core_write(3, 32'h402); push_exp(3, 32'h402);
        half(); check("t3_full", mc_bus.mc_ready, 0); tick();
        idle(); push_exp(8, 32'h88);
        half(); check("t3_full_drain", mc_bus.mc_ready, 0); tick();
        idle(); push_exp(9, 32'h99);
        half(); check("t3_ready_again", mc_bus.mc_ready, 1); tick();
        idle();
        half(); check("t3_err", err, 0); tick();

        // Re-claim r6 in the cycle its result drains.
        claim(6);
        idle(); mc_push(6, 32'h66); push_exp(6, 32'h66); tick();
        idle(); issue_claim = 1'b1; issue_wa = 6; ra2 = 6;
        half(); check("t4_hazard_drain", hazard2, 1); tick();
        idle(); ra2 = 6;
        half(); check("t4_hazard_kept", hazard2, 1); check("t4_err_reclaim", err, 1); tick();

        reset = 1'b1; idle(); tick();
        reset = 1'b0; ra2 = 6;
        half(); check("t4_rst_err", err, 0); check("t4_rst_hazard", hazard2, 0); tick();

        // Unclaimed push, then a wa=0 push that pops silently.
        idle(); mc_push(4, 32'h44); push_exp(4, 32'h44); tick();
        idle();
        half(); check("t5_err_set", err, 1); tick();
        idle();
        half(); check("t5_err_sticky", err, 1); tick();
        idle(); mc_push(0, 32'hdead); tick();
        idle();
        half(); check("t5_zero_no_we", rf_we, 0); tick();

        reset = 1'b1; idle(); tick();
        reset = 1'b0;
        half(); check("t5_rst_err", err, 0); tick();

        // Core write to a busy register.
        claim(5);
        idle(); core_write(5, 32'h55); push_exp(5, 32'h55);
        half(); check("t5_err_before", err, 0); tick();
        idle();
        half(); check("t5_core_busy_err", err, 1); tick();

        // Reset with two entries queued.
        claim(10);
        claim(11);
        idle(); core_write(3, 32'h500); mc_push(10, 32'haa); push_exp(3, 32'h500); tick();
        idle(); core_write(3, 32'h501); mc_push(11, 32'hbb); push_exp(3, 32'h501);
        half(); check("t6_ready_one", mc_bus.mc_ready, 1); tick();
        idle(); core_write(3, 32'h502); push_exp(3, 32'h502);
        half(); check("t6_full", mc_bus.mc_ready, 0); tick();
        for (int i = 0; i < 2; i++) begin
            idle(); core_write(3, 32'h600); reset = 1'b1;
            half();
            check($sformatf("t6_rst_we_%0d", i), rf_we, 0);
            check($sformatf("t6_rst_ready_%0d", i), mc_bus.mc_ready, 0);
            check($sformatf("t6_rst_stall_%0d", i), stall_core, 0);
            tick();
        end
        reset = 1'b0; idle(); ra1 = 10; ra2 = 11;
        half();
        check("t6_hazard1", hazard1, 0);
        check("t6_hazard2", hazard2, 0);
        check("t6_err", err, 0);
        check("t6_ready", mc_bus.mc_ready, 1);
        check("t6_no_we", rf_we, 0);
        tick();
        idle();
        half(); check("t6_no_we_next", rf_we, 0); tick();

        check("exp_queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
